// File: rtl/cpu_ctrl.sv
// Hack CPU control unit: sequences A/C instructions through an
// external ALU and a handshaked data memory.
module cpu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_ctl,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [14:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [14:0] pc,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WRITE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] a;
    logic [15:0] d;
    logic [12:0] ir;
    logic [15:0] mdr;
    logic [15:0] r;
    logic [14:0] waddr;
    logic [14:0] pc_q;
    logic [14:0] pc_inc;
    logic        take;

    assign pc_inc = pc_q + 15'd1;
    assign take = (ir[2] & alu_ng) | (ir[1] & alu_zr)
                | (ir[0] & ~alu_ng & ~alu_zr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (instr_valid && instr[15]) begin
                    state_nx = instr[12] ? READ : EXEC;
                end
            end
            READ: begin
                if (mem_ack) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                state_nx = ir[3] ? WRITE : IDLE;
            end
            WRITE: begin
                if (mem_ack) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Jump target and write address both use A as it was before EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a     <= '0;
            d     <= '0;
            ir    <= '0;
            mdr   <= '0;
            r     <= '0;
            waddr <= '0;
            pc_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        if (!instr[15]) begin
                            a    <= instr;
                            pc_q <= pc_inc;
                        end else begin
                            ir <= instr[12:0];
                        end
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        mdr <= mem_rdata;
                    end
                end
                EXEC: begin
                    r     <= alu_out;
                    waddr <= a[14:0];
                    if (ir[4]) begin
                        d <= alu_out;
                    end
                    if (ir[5]) begin
                        a <= alu_out;
                    end
                    pc_q <= take ? a[14:0] : pc_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        instr_ready = (state == IDLE);
        mem_rd      = (state == READ);
        mem_wr      = (state == WRITE);
        mem_addr    = (state == WRITE) ? waddr : a[14:0];
    end

    assign mem_wdata = r;
    assign alu_x     = d;
    assign alu_y     = ir[12] ? mdr : a;
    assign alu_ctl   = ir[11:6];
    assign pc        = pc_q;
    assign a_reg     = a;
    assign d_reg     = d;

endmodule
